// File: rtl/acc_pkg.sv
// Shared widths, activation selector and saturation helpers for the acc_pipe accelerator.
package acc_pkg;
    localparam int DW    = 8;
    localparam int AW    = 18;
    localparam int N_IN  = 4;
    localparam int N_HID = 4;

    typedef enum logic {ACT_RELU, ACT_LIN} act_e;

    // Identity hidden layer: W1[k][k] = 1, byte [k][i] sits at bits (k*4+i)*8.
    localparam logic [N_HID-1:0][N_IN-1:0][DW-1:0] W1_DEFAULT =
        128'h01000000_00010000_00000100_00000001;

    function automatic logic [DW-1:0] sat_relu(input logic signed [AW-1:0] v);
        if (v < 18'sd0)
            return '0;
        else if (v > 18'sd127)
            return 8'd127;
        else
            return v[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] sat_s8(input logic signed [AW-1:0] v);
        if (v > 18'sd127)
            return 8'h7f;
        else if (v < -18'sd128)
            return 8'h80;
        else
            return v[DW-1:0];
    endfunction
endpackage

// File: rtl/acc_neuron.sv
// One neuron: 4 signed products plus bias, arithmetic shift, activation, registered output.
// One cycle latency; output register only updates when en is high.
module acc_neuron
    import acc_pkg::*;
#(
    parameter logic [N_IN-1:0][DW-1:0] W     = '0,
    parameter logic [DW-1:0]           B     = '0,
    parameter int                      SHIFT = 0,
    parameter act_e                    ACT   = ACT_RELU
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_IN-1:0][DW-1:0]   x,
    output logic [DW-1:0]             y
);
    logic signed [AW-1:0]   sum;
    logic signed [AW-1:0]   shifted;
    logic signed [2*DW-1:0] xe;
    logic signed [2*DW-1:0] we;
    logic signed [2*DW-1:0] prod;
    logic [DW-1:0]          y_d;
    logic [DW-1:0]          y_q;

    always_comb begin
        sum  = AW'($signed(B));
        xe   = '0;
        we   = '0;
        prod = '0;
        for (int i = 0; i < N_IN; i++) begin
            xe   = (2*DW)'($signed(x[i]));
            we   = (2*DW)'($signed(W[i]));
            prod = xe * we;
            sum  = sum + AW'(prod);
        end
        shifted = sum >>> SHIFT;
        y_d = y_q;
        if (en)
            y_d = (ACT == ACT_RELU) ? sat_relu(shifted) : sat_s8(shifted);
    end

    always_ff @(posedge clk) begin
        if (rst)
            y_q <= '0;
        else
            y_q <= y_d;
    end

    assign y = y_q;
endmodule

// File: rtl/acc_pipe.sv
// Three-stage 4-4-1 fixed-point MLP: input register, hidden ReLU layer, linear output.
// All stages advance together when the output slot is empty or being drained.
module acc_pipe
    import acc_pkg::*;
#(
    parameter logic [N_HID-1:0][N_IN-1:0][DW-1:0] W1    = W1_DEFAULT,
    parameter logic [N_HID-1:0][DW-1:0]           B1    = '0,
    parameter logic [N_HID-1:0][DW-1:0]           W2    = 32'h01010101,
    parameter logic [DW-1:0]                      B2    = '0,
    parameter int                                 SHIFT = 0
) (
    input  logic          clk,
    input  logic          arst,
    input  logic [DW-1:0] X1,
    input  logic [DW-1:0] X2,
    input  logic [DW-1:0] X3,
    input  logic [DW-1:0] X4,
    input  logic          valid,
    output logic          ready,
    output logic [DW-1:0] Y,
    output logic          valid_out,
    input  logic          ready_out
);
    logic                     en;
    logic [N_IN-1:0][DW-1:0]  x_d, x_q;
    logic                     v1_d, v1_q;
    logic                     v2_d, v2_q;
    logic                     v3_d, v3_q;
    logic [N_HID-1:0][DW-1:0] hid;

    assign en        = !v3_q || ready_out;
    assign ready     = en && !arst;
    assign valid_out = v3_q;

    always_comb begin
        x_d  = x_q;
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        if (en) begin
            x_d  = {X4, X3, X2, X1};
            v1_d = valid;
            v2_d = v1_q;
            v3_d = v2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            x_q  <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
        end
    end

    for (genvar k = 0; k < N_HID; k++) begin : g_hid
        acc_neuron #(
            .W     (W1[k]),
            .B     (B1[k]),
            .SHIFT (SHIFT),
            .ACT   (ACT_RELU)
        ) u_hid (
            .clk (clk),
            .rst (arst),
            .en  (en),
            .x   (x_q),
            .y   (hid[k])
        );
    end

    acc_neuron #(
        .W     (W2),
        .B     (B2),
        .SHIFT (SHIFT),
        .ACT   (ACT_LIN)
    ) u_out (
        .clk (clk),
        .rst (arst),
        .en  (en),
        .x   (hid),
        .y   (Y)
    );
endmodule

// File: tb/tb_acc_pipe.sv
// Directed and seeded-random checks of acc_pipe with default parameters.
module tb_acc_pipe;
    logic       clk = 1'b0;
    logic       arst;
    logic [7:0] X1, X2, X3, X4;
    logic       valid;
    logic       ready;
    logic [7:0] Y;
    logic       valid_out;
    logic       ready_out;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int obs_q[$];

    always #5 clk = ~clk;

    acc_pipe dut (
        .clk       (clk),
        .arst      (arst),
        .X1        (X1),
        .X2        (X2),
        .X3        (X3),
        .X4        (X4),
        .valid     (valid),
        .ready     (ready),
        .Y         (Y),
        .valid_out (valid_out),
        .ready_out (ready_out)
    );

    // Reference network with the default weights: identity hidden layer, all-ones output layer.
    function automatic int model(input int a, input int b, input int c, input int d);
        int x[4];
        int acc;
        int h;
        int s;
        x[0] = a; x[1] = b; x[2] = c; x[3] = d;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            acc = 0;
            for (int i = 0; i < 4; i++)
                acc += ((k == i) ? 1 : 0) * x[i];
            h = (acc < 0) ? 0 : ((acc > 127) ? 127 : acc);
            s += 1 * h;
        end
        return (s > 127) ? 127 : ((s < -128) ? -128 : s);
    endfunction

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    // Called at a negedge with inputs already driven; records handshakes and advances one edge.
    task automatic cycle();
        #1;
        if (valid && ready)
            exp_q.push_back(model(sx(X1), sx(X2), sx(X3), sx(X4)));
        if (valid_out && ready_out)
            obs_q.push_back(sx(Y));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_x(input int a, input int b, input int c, input int d);
        X1 = 8'(a); X2 = 8'(b); X3 = 8'(c); X4 = 8'(d);
    endtask

    task automatic test_reset();
        arst = 1'b1; valid = 1'b0; ready_out = 1'b1;
        set_x(0, 0, 0, 0);
        repeat (5) cycle();
        #1;
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out got=%b want=0", valid_out); end
        total++; if (Y !== 8'd0) begin bad++; $display("FAIL reset_y got=%0d want=0", Y); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
        arst = 1'b0;
        cycle();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", ready); end
    endtask

    // Acceptance edge counts as the first of three register edges.
    task automatic test_latency();
        exp_q.delete(); obs_q.delete();
        set_x(10, -5, 20, 3); valid = 1'b1;
        cycle();
        valid = 1'b0;
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL lat_edge1 got=%b want=0", valid_out); end
        cycle();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL lat_edge2 got=%b want=0", valid_out); end
        cycle();
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL lat_edge3_valid got=%b want=1", valid_out); end
        total++; if (sx(Y) !== 33) begin bad++; $display("FAIL lat_y got=%0d want=33", sx(Y)); end
        repeat (2) cycle();
    endtask

    task automatic test_saturation();
        exp_q.delete(); obs_q.delete();
        set_x(100, 100, 0, 0); valid = 1'b1;
        cycle();
        set_x(-1, -128, -50, -7);
        cycle();
        valid = 1'b0;
        cycle();
        total++; if (valid_out !== 1'b1 || sx(Y) !== 127) begin bad++; $display("FAIL sat_high got=%0d/%b want=127/1", sx(Y), valid_out); end
        cycle();
        total++; if (valid_out !== 1'b1 || sx(Y) !== 0) begin bad++; $display("FAIL relu_zero got=%0d/%b want=0/1", sx(Y), valid_out); end
        repeat (2) cycle();
    endtask

    task automatic test_back_to_back();
        exp_q.delete(); obs_q.delete();
        ready_out = 1'b1;
        for (int c = 0; c < 400 && obs_q.size() < 100; c++) begin
            valid = (exp_q.size() < 100);
            set_x($urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255));
            cycle();
        end
        valid = 1'b0;
        total++; if (obs_q.size() !== 100) begin bad++; $display("FAIL b2b_count got=%0d want=100", obs_q.size()); end
        for (int i = 0; i < 100 && i < obs_q.size() && i < exp_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_y[%0d] got=%0d want=%0d", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        int held_y;
        logic held_v;
        int n;
        exp_q.delete(); obs_q.delete();
        held_y = 0; held_v = 1'b0;
        for (int c = 0; c < 60 && obs_q.size() < 10; c++) begin
            n = exp_q.size();
            valid = (n < 10);
            set_x(n * 7 - 20, 3 - n, n * 5, 60 - n * 9);
            ready_out = !(c >= 5 && c < 9);
            #1;
            if (c == 5) begin
                held_y = sx(Y); held_v = valid_out;
                total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL stall_full got=%b want=1", valid_out); end
            end
            if (c >= 5 && c < 9) begin
                total++; if (ready !== 1'b0) begin bad++; $display("FAIL stall_ready c=%0d got=%b want=0", c, ready); end
            end
            if (c >= 6 && c < 9) begin
                total++; if (sx(Y) !== held_y || valid_out !== held_v) begin bad++; $display("FAIL stall_hold c=%0d got=%0d/%b want=%0d/%b", c, sx(Y), valid_out, held_y, held_v); end
            end
            cycle();
        end
        valid = 1'b0; ready_out = 1'b1;
        total++; if (obs_q.size() !== 10) begin bad++; $display("FAIL stall_count got=%0d want=10", obs_q.size()); end
        for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== model(i * 7 - 20, 3 - i, i * 5, 60 - i * 9)) begin bad++; $display("FAIL stall_y[%0d] got=%0d want=%0d", i, obs_q[i], model(i * 7 - 20, 3 - i, i * 5, 60 - i * 9)); end
        end
    endtask

    task automatic test_arst_flush();
        exp_q.delete(); obs_q.delete();
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            set_x(20 + i, 30, 40, 5);
            cycle();
        end
        valid = 1'b0;
        total++; if (exp_q.size() !== 3 || valid_out !== 1'b1) begin bad++; $display("FAIL flush_fill got=%0d/%b want=3/1", exp_q.size(), valid_out); end
        arst = 1'b1;
        cycle();
        total++; if (valid_out !== 1'b0 || Y !== 8'd0) begin bad++; $display("FAIL flush_clear got=%0d/%b want=0/0", sx(Y), valid_out); end
        arst = 1'b0; ready_out = 1'b1;
        repeat (8) cycle();
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL flush_leak got=%0d want=0", obs_q.size()); end
    endtask

    initial begin
        arst = 1'b1; valid = 1'b0; ready_out = 1'b1;
        X1 = '0; X2 = '0; X3 = '0; X4 = '0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_saturation();
        test_back_to_back();
        test_stall();
        test_arst_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
